inst_fetch_unit: RTL
====================

// Module: inst_fetch_unit
// PURPOSE
//  Instruction fetch front-end of the Scpu core; reads the combinational instruction ROM.
//  - Owns the fetch PC and drives the ROM word address.
//  - Captures {pc, inst} pairs into a small prefetch FIFO and presents them to decode.
//  - Decode is fed over a valid/ready handshake.
//  - Accepts branch/jump redirects from execute and flushes stale prefetched entries.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC loaded on reset
//  FIFO_DEPTH  2              prefetch entries; power of 2, >= 2
//  NOP_INST    32'h0000_0013  value driven on if_inst when the FIFO is empty
// PORTS
//  clk             in   1   core clock; rising edge
//  rst_n           in   1   asynchronous, active-low reset
//  imem_addr       out  32  byte address to the ROM; equals fetch PC
//  imem_inst       in   32  ROM data; combinational from imem_addr, same cycle
//  fetch_en        in   1   1 = fetching allowed; 0 = hold PC, no push
//  redirect_valid  in   1   execute requests a PC change (taken branch/jump)
//  redirect_pc     in   32  target; bits [1:0] forced to 0
//  if_valid        out  1   FIFO head holds a valid instruction
//  if_inst         out  32  head instruction; NOP_INST when empty
//  if_pc           out  32  head PC; 0 when empty
//  id_ready        in   1   decode accepts the head this cycle
// BEHAVIOUR
//  Reset (async, any time, mid-operation included):
//   - pc = RESET_PC, FIFO count = 0, rd/wr pointers = 0.
//   - if_valid = 0, if_inst = NOP_INST, if_pc = 0, imem_addr = RESET_PC.
//  Cycle rules:
//   - pop = if_valid & id_ready.
//   - push = fetch_en & !redirect_valid & (count < FIFO_DEPTH | pop).
//   - On push, {pc, imem_inst} is written at the edge and pc <= pc + 4.
//     PC wraps modulo 2^32; 0xFFFF_FFFC -> 0.
//  Latency: a PC presented on imem_addr in cycle N appears on if_valid/if_pc/if_inst in cycle N+1.
//  Full: count == FIFO_DEPTH and no pop -> no push, PC holds, imem_addr is stable.
//   - Nothing is lost or duplicated.
//  Full with pop: push and pop occur in the same cycle; count is unchanged.
//  Empty with push: count becomes 1. The FIFO has no fall-through; empty stays invisible for that cycle.
//  Redirect (highest priority):
//   - The same-cycle pop still completes; decode owns that instruction.
//   - Every other entry is flushed: count <= 0.
//   - pc <= {redirect_pc[31:2], 2'b00}.
//   - No push happens in the redirect cycle.
//   - The target reaches if_valid 2 cycles after the redirect cycle. No wrong-path instruction appears after the redirect edge.
//  Back-to-back redirects: the last one wins; each flushes.
//  fetch_en = 0: PC holds and pushes stop; pops and redirects still act.
//  Handshake: while if_valid = 1 and id_ready = 0, if_inst/if_pc stay stable until accepted or flushed.
//  Output encoding: if_valid = (count != 0); pointers are log2(FIFO_DEPTH) bits and wrap naturally.
// STRUCTURE
//  Shared package scpu_pkg:
//   - XLEN = 32, NOP_INST, RESET_PC default.
//   - fetch_entry_t = {pc[31:0], inst[31:0]}.
//  Sub-module fetch_fifo:
//   - Synchronous FIFO of fetch_entry_t, depth FIFO_DEPTH.
//   - Ports push/pop/flush/full/empty/count; flush has priority over push and equals pop semantics.
//  Top level holds the PC register, the push/pop/redirect arbitration and the output muxing.
// TESTING (bench instantiates fibonacci_imem as the ROM)
//  1. Release reset, fetch_en = 1, id_ready = 1:
//     cycle 1 -> if_pc = 0x0, if_inst = 0x00100093;
//     cycle 2 -> if_pc = 0x4, if_inst = 0x00100113;
//     one instruction per cycle from then on.
//  2. Backpressure:
//     id_ready = 0 for 5 cycles after cycle 1 -> count saturates at 2, imem_addr holds at 0x8, head stays at pc 0x0;
//     release -> 0x0, 0x4, 0x8 in order, none missing or repeated.
//  3. Redirect to 0x20 while the FIFO is full and id_ready = 1 -> head is popped that cycle, rest flushed;
//     2 cycles later if_pc = 0x20, if_inst = 0x002081b3.
//  4. Redirect to 0x22 -> treated as 0x20.
//     Redirect in two consecutive cycles (0x20, then 0x38) -> only 0x38 (0xfe5244e3) is delivered.
//  5. fetch_en = 0 for 3 cycles with id_ready = 1 -> FIFO drains, if_valid = 0, if_inst = 0x00000013, PC frozen;
//     re-enable -> fetch resumes at the frozen PC.
//  6. Assert rst_n low mid-stream, between clock edges -> if_valid = 0 and imem_addr = 0 immediately;
//     after release, sequence restarts at pc 0x0.

Source files
------------

// File: rtl/scpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : scpu_pkg
//  Description : Shared types and constants for the Scpu core front-end.
//                XLEN, the canonical NOP encoding, the default reset PC and
//                the {pc, inst} record that travels through the prefetch FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
package scpu_pkg;

   localparam int unsigned XLEN = 32;

   // addi x0, x0, 0
   localparam logic [XLEN-1:0] NOP_INST_DEFAULT = 32'h0000_0013;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
   } fetch_entry_t;

endpackage : scpu_pkg
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : Synchronous prefetch FIFO of fetch_entry_t, no fall-through.
//                Flush empties the FIFO and wins over push; a pop requested
//                in the flush cycle is still honoured by the reader because
//                the head is presented combinationally.
//  Ports       : clk, rst_n      - clock, async active-low reset
//                push_i, wdata_i - write request and entry
//                pop_i           - consume head entry
//                flush_i         - discard all entries
//                rdata_o         - head entry (undefined when empty)
//                full_o, empty_o - occupancy flags
//                count_o         - number of valid entries
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
   import scpu_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic                     flush_i,
   input  fetch_entry_t             wdata_i,
   output fetch_entry_t             rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned     PTR_W   = $clog2(DEPTH);
   localparam logic [PTR_W:0]  DEPTH_C = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]  ONE_C   = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] ONE_P  = PTR_W'(1);

   fetch_entry_t        mem_q [DEPTH];
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]      count_q,  count_d;
   logic                w_do_push;
   logic                w_do_pop;

   assign full_o    = (count_q == DEPTH_C);
   assign empty_o   = (count_q == '0);
   assign count_o   = count_q;
   assign rdata_o   = mem_q[rd_ptr_q];

   assign w_do_pop  = pop_i & ~empty_o;
   // A full FIFO may still accept a write when the head leaves this cycle.
   assign w_do_push = push_i & ~flush_i & (~full_o | w_do_pop);

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (w_do_pop)  rd_ptr_d = rd_ptr_q + ONE_P;
         if (w_do_push) wr_ptr_d = wr_ptr_q + ONE_P;
         case ({w_do_push, w_do_pop})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: an entry is only visible once count covers it.
   always_ff @(posedge clk) begin
      if (w_do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetch_unit
//  Description : Scpu instruction fetch front-end. Owns the fetch PC, reads
//                the combinational instruction ROM, buffers {pc, inst} pairs
//                in a prefetch FIFO and hands them to decode over
//                valid/ready. Redirects from execute reload the PC and flush
//                every prefetched entry not accepted in the same cycle.
//  Ports       : clk, rst_n             - clock, async active-low reset
//                imem_addr / imem_inst  - ROM address (= PC) and data
//                fetch_en               - allow fetching
//                redirect_valid/_pc     - branch/jump target from execute
//                if_valid/if_inst/if_pc - head entry towards decode
//                id_ready               - decode accepts head
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_unit
   import scpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
   parameter int unsigned FIFO_DEPTH = 2,
   parameter logic [31:0] NOP_INST   = NOP_INST_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_inst,
   input  logic        fetch_en,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   output logic [31:0] if_inst,
   output logic [31:0] if_pc,
   input  logic        id_ready
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic [31:0]      pc_q, pc_d;
   logic             w_push;
   logic             w_pop;
   logic             w_fifo_full;
   logic             w_fifo_empty;
   logic [CNT_W-1:0] w_fifo_count;
   fetch_entry_t     w_wr_entry;
   fetch_entry_t     w_head;

   assign imem_addr  = pc_q;
   assign if_valid   = (w_fifo_count != '0);
   assign if_inst    = w_fifo_empty ? NOP_INST : w_head.inst;
   assign if_pc      = w_fifo_empty ? 32'h0    : w_head.pc;

   assign w_pop      = if_valid & id_ready;
   // A redirect makes the instruction at the current PC wrong-path, so it
   // is never captured.
   assign w_push     = fetch_en & ~redirect_valid & (~w_fifo_full | w_pop);
   assign w_wr_entry = '{pc: pc_q, inst: imem_inst};

   always_comb begin
      pc_d = pc_q;
      if (redirect_valid) begin
         pc_d = {redirect_pc[31:2], 2'b00};
      end else if (w_push) begin
         pc_d = pc_q + 32'd4;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   fetch_fifo #(
      .DEPTH   (FIFO_DEPTH)
   ) u_fetch_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (w_push),
      .pop_i   (w_pop),
      .flush_i (redirect_valid),
      .wdata_i (w_wr_entry),
      .rdata_o (w_head),
      .full_o  (w_fifo_full),
      .empty_o (w_fifo_empty),
      .count_o (w_fifo_count)
   );

endmodule : inst_fetch_unit
`default_nettype wire
